// File: rtl/vga_scanout.sv
// VGA scan-out: raster counters, framebuffer address generation and a latency-matched pixel/sync pipeline.
// Build macro TEST_PATTERN_EN adds input test_pattern_in, which replaces memory pixels with hcount[7:4].

module vga_scanout #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int PIX_BITS     = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_BITS    = 19
) (
  input  logic                 vga_clk_in,
  input  logic                 rst_in,
`ifdef TEST_PATTERN_EN
  input  logic                 test_pattern_in,
`endif
  input  logic [PIX_BITS-1:0]  read_data_in,
  output logic [ADDR_BITS-1:0] read_addr_out,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start_out,
  output logic                 vblank_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DEPTH   = READ_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_BITS-1:0] LINE_WORDS = ADDR_BITS'(H_ACTIVE >> SCALE_LOG2);
  localparam logic                 SYNC_ON    = (SYNC_POL != 0);

  // One entry per pipeline stage; sync flags are kept un-polarised until the pins.
  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       tp_en;
    logic [3:0] tp_pix;
  } stage_t;

  logic [HW-1:0]        hcount_q, hcount_d;
  logic [VW-1:0]        vcount_q, vcount_d;
  logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
  logic [3:0]           pix_q, pix_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  stage_t               stage_q [DEPTH];
  stage_t               stage_d [DEPTH];
  stage_t               stage_in;
  stage_t               stage_last;

  logic                 pos_active;
  logic [15:0]          h_ext;
  logic [ADDR_BITS-1:0] addr_row;
  logic [ADDR_BITS-1:0] addr_col;
  logic                 unused_ok;

  // Raster counters
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
    end else begin
      hcount_d = hcount_q + HW'(1);
    end
  end

  always_ff @(posedge vga_clk_in) begin
    if (rst_in) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign pos_active = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
  assign h_ext      = 16'(hcount_q);

  // Framebuffer address, full-width product; blank positions fetch address 0.
  always_comb begin
    addr_row    = ADDR_BITS'(vcount_q >> SCALE_LOG2);
    addr_col    = ADDR_BITS'(hcount_q >> SCALE_LOG2);
    read_addr_d = '0;
    if (pos_active) begin
      read_addr_d = addr_row * LINE_WORDS + addr_col;
    end
  end

  always_ff @(posedge vga_clk_in) begin
    if (rst_in) begin
      read_addr_q <= '0;
    end else begin
      read_addr_q <= read_addr_d;
    end
  end

  // Stage 0 aligns with read_addr_q; stage DEPTH-1 aligns with read_data_in.
  always_comb begin
    stage_in        = '0;
    stage_in.active = pos_active;
    stage_in.hsync  = (hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END);
    stage_in.vsync  = (vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END);
`ifdef TEST_PATTERN_EN
    stage_in.tp_en  = test_pattern_in;
`else
    stage_in.tp_en  = 1'b0;
`endif
    stage_in.tp_pix = h_ext[7:4];
  end

  always_comb begin
    stage_d[0] = stage_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge vga_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Output register: colour, hsync and vsync leave through the same flop stage.
  always_comb begin
    stage_last = stage_q[DEPTH-1];
    pix_d      = 4'h0;
    if (stage_last.active) begin
      pix_d = stage_last.tp_en ? stage_last.tp_pix : read_data_in[PIX_BITS-1 -: 4];
    end
    hs_d = stage_last.hsync ? SYNC_ON : ~SYNC_ON;
    vs_d = stage_last.vsync ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge vga_clk_in) begin
    if (rst_in) begin
      pix_q <= 4'h0;
      hs_q  <= ~SYNC_ON;
      vs_q  <= ~SYNC_ON;
    end else begin
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign read_addr_out   = read_addr_q;
  assign vga_r           = pix_q;
  assign vga_g           = pix_q;
  assign vga_b           = pix_q;
  assign vga_hs          = hs_q;
  assign vga_vs          = vs_q;
  // Gated by reset so the pulse belongs to the first released cycle only.
  assign frame_start_out = (hcount_q == '0) && (vcount_q == '0) && !rst_in;
  assign vblank_out      = (vcount_q >= V_ACT_C);

  assign unused_ok = ^{h_ext[15:8], h_ext[3:0], read_data_in};

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default timing, long read latency, 2x upscale and a tiny raster.
// Bench cycle n counts clocks since reset release; counters hold position n at cycle n.

module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n;
  int   tests  = 0;
  int   failed = 0;
`ifdef TEST_PATTERN_EN
  logic tp = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // Instance A: default parameters, memory returns addr[3:0] after 2 cycles
  logic [18:0] addr_a;
  logic [3:0]  r_a, g_a, b_a, mem_a1, mem_a2;
  logic        hs_a, vs_a, fs_a, vb_a;
  always @(posedge clk) begin
    mem_a1 <= addr_a[3:0];
    mem_a2 <= mem_a1;
  end
  vga_scanout dut_a (
    .vga_clk_in(clk), .rst_in(rst),
`ifdef TEST_PATTERN_EN
    .test_pattern_in(tp),
`endif
    .read_data_in(mem_a2), .read_addr_out(addr_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .frame_start_out(fs_a), .vblank_out(vb_a));

  // Instance B: 24x13 raster, SYNC_POL=1, 6-bit pixels, latency 1, memory returns {~addr[3:0],2'b01}
  logic [7:0] addr_b;
  logic [5:0] mem_b1;
  logic [3:0] r_b, g_b, b_b;
  logic       hs_b, vs_b, fs_b, vb_b;
  always @(posedge clk) mem_b1 <= {~addr_b[3:0], 2'b01};
  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1), .PIX_BITS(6), .READ_LATENCY(1), .ADDR_BITS(8)
  ) dut_b (
    .vga_clk_in(clk), .rst_in(rst),
`ifdef TEST_PATTERN_EN
    .test_pattern_in(tp),
`endif
    .read_data_in(mem_b1), .read_addr_out(addr_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .frame_start_out(fs_b), .vblank_out(vb_b));

  // Instance C: SCALE_LOG2=1, only the address path is checked
  logic [18:0] addr_c;
  logic [3:0]  r_c, g_c, b_c;
  logic [3:0]  data_c = 4'h0;
  logic        hs_c, vs_c, fs_c, vb_c;
  vga_scanout #(.SCALE_LOG2(1)) dut_c (
    .vga_clk_in(clk), .rst_in(rst),
`ifdef TEST_PATTERN_EN
    .test_pattern_in(tp),
`endif
    .read_data_in(data_c), .read_addr_out(addr_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .vga_hs(hs_c), .vga_vs(vs_c),
    .frame_start_out(fs_c), .vblank_out(vb_c));

  // Instance D: READ_LATENCY=4, memory returns addr[3:0] after 4 cycles
  logic [18:0] addr_d;
  logic [3:0]  r_d, g_d, b_d, mem_d1, mem_d2, mem_d3, mem_d4;
  logic        hs_d, vs_d, fs_d, vb_d;
  always @(posedge clk) begin
    mem_d1 <= addr_d[3:0];
    mem_d2 <= mem_d1;
    mem_d3 <= mem_d2;
    mem_d4 <= mem_d3;
  end
  vga_scanout #(.READ_LATENCY(4)) dut_d (
    .vga_clk_in(clk), .rst_in(rst),
`ifdef TEST_PATTERN_EN
    .test_pattern_in(tp),
`endif
    .read_data_in(mem_d4), .read_addr_out(addr_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .vga_hs(hs_d), .vga_vs(vs_d),
    .frame_start_out(fs_d), .vblank_out(vb_d));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n=%0d", n);
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if ({r_a, g_a, b_a} !== 12'h000) begin failed++; $display("FAIL reset_rgb_a: got %h want 000", {r_a, g_a, b_a}); end
    tests++; if ({hs_a, vs_a} !== 2'b11) begin failed++; $display("FAIL reset_sync_a: got %b want 11", {hs_a, vs_a}); end
    tests++; if ({hs_b, vs_b} !== 2'b00) begin failed++; $display("FAIL reset_sync_b: got %b want 00", {hs_b, vs_b}); end
    tests++; if ({fs_a, vb_a, fs_b, vb_b} !== 4'b0000) begin failed++; $display("FAIL reset_flags: got %b want 0000", {fs_a, vb_a, fs_b, vb_b}); end
    tests++; if (addr_a !== 19'd0) begin failed++; $display("FAIL reset_addr_a: got %0d want 0", addr_a); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (fs_a !== 1'b1) begin failed++; $display("FAIL reset_release_fs: got %b want 1", fs_a); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_hsync_timing();
    int a_low = 0, a_first = -1, d_low = 0, d_first = -1, fs_cnt = 0, vb_cnt = 0, vs_low = 0;
    apply_reset();
    for (int t = 0; t <= 830; t++) begin
      @(negedge clk);
      if (hs_a == 1'b0) begin a_low++; if (a_first < 0) a_first = n; end
      if (hs_d == 1'b0) begin d_low++; if (d_first < 0) d_first = n; end
      if (vs_a == 1'b0) vs_low++;
      if (fs_a) fs_cnt++;
      if (vb_a) vb_cnt++;
    end
    tests++; if (a_first != 660) begin failed++; $display("FAIL hs_edge_a: got %0d want 660", a_first); end
    tests++; if (a_low != 96) begin failed++; $display("FAIL hs_width_a: got %0d want 96", a_low); end
    tests++; if (d_first != 662) begin failed++; $display("FAIL hs_edge_rl4: got %0d want 662", d_first); end
    tests++; if (d_low != 96) begin failed++; $display("FAIL hs_width_rl4: got %0d want 96", d_low); end
    tests++; if (fs_cnt != 1) begin failed++; $display("FAIL frame_start_count_a: got %0d want 1", fs_cnt); end
    tests++; if (vb_cnt != 0 || vs_low != 0) begin failed++; $display("FAIL line0_vblank_vs: got vb=%0d vs_low=%0d want 0 0", vb_cnt, vs_low); end
    $display("[TB] test_hsync_timing done: hs_a first=%0d width=%0d, hs_d first=%0d", a_first, a_low, d_first);
  endtask

  task automatic test_pixel_path();
    apply_reset();
    for (int t = 0; t <= 812; t++) begin
      @(negedge clk);
      if (n == 6) begin
        tests++; if (addr_a !== 19'd5) begin failed++; $display("FAIL addr_a_h5: got %0d want 5", addr_a); end
      end
      if (n == 9) begin
        tests++; if ({r_a, g_a, b_a} !== 12'h555) begin failed++; $display("FAIL pix_a_h5: got %h want 555", {r_a, g_a, b_a}); end
      end
      if (n == 643) begin
        tests++; if (r_a !== 4'hF) begin failed++; $display("FAIL pix_a_h639: got %h want f", r_a); end
      end
      if (n == 644) begin
        tests++; if (r_a !== 4'h0) begin failed++; $display("FAIL pix_a_h640_blank: got %h want 0", r_a); end
      end
      if (n == 645) begin
        tests++; if (r_d !== 4'hF) begin failed++; $display("FAIL pix_rl4_h639: got %h want f", r_d); end
      end
      if (n == 646) begin
        tests++; if (r_d !== 4'h0) begin failed++; $display("FAIL pix_rl4_h640_blank: got %h want 0", r_d); end
      end
      if (n == 701) begin
        tests++; if (addr_a !== 19'd0) begin failed++; $display("FAIL addr_a_blank: got %0d want 0", addr_a); end
      end
      if (n == 811) begin
        tests++; if (addr_a !== 19'd650) begin failed++; $display("FAIL addr_a_h10_v1: got %0d want 650", addr_a); end
      end
    end
    $display("[TB] test_pixel_path done");
  endtask

  task automatic test_scaling();
    apply_reset();
    for (int t = 0; t <= 2405; t++) begin
      @(negedge clk);
      if (n == 1602) begin
        tests++; if (addr_c !== 19'd320) begin failed++; $display("FAIL scale_addr_1_2: got %0d want 320", addr_c); end
      end
      if (n == 1603 || n == 1604 || n == 2403 || n == 2404) begin
        tests++; if (addr_c !== 19'd321) begin failed++; $display("FAIL scale_addr_shared n=%0d: got %0d want 321", n, addr_c); end
      end
      if (n == 1605) begin
        tests++; if (addr_c !== 19'd322) begin failed++; $display("FAIL scale_addr_4_2: got %0d want 322", addr_c); end
      end
    end
    $display("[TB] test_scaling done");
  endtask

  task automatic test_small_frame();
    int fs_cnt = 0, vb_cnt = 0, vb_first = -1, vs_cnt = 0, vs_first = -1, hs_cnt = 0;
    apply_reset();
    for (int t = 0; t <= 330; t++) begin
      @(negedge clk);
      if (fs_b) fs_cnt++;
      if (n < 312) begin
        if (vb_b) begin vb_cnt++; if (vb_first < 0) vb_first = n; end
        if (vs_b) begin vs_cnt++; if (vs_first < 0) vs_first = n; end
        if (hs_b) hs_cnt++;
      end
      if (n == 312) begin
        tests++; if (fs_b !== 1'b1) begin failed++; $display("FAIL small_fs_wrap: got %b want 1", fs_b); end
      end
      if (n == 54) begin
        tests++; if (addr_b !== 8'd37) begin failed++; $display("FAIL small_addr_5_2: got %0d want 37", addr_b); end
      end
      if (n == 56) begin
        tests++; if ({r_b, g_b, b_b} !== 12'hAAA) begin failed++; $display("FAIL small_pix_5_2: got %h want aaa", {r_b, g_b, b_b}); end
      end
      if (n == 68) begin
        tests++; if (r_b !== 4'h0) begin failed++; $display("FAIL small_hblank_17_2: got %h want 0", r_b); end
      end
      if (n == 224) begin
        tests++; if (r_b !== 4'h0) begin failed++; $display("FAIL small_vblank_5_9: got %h want 0", r_b); end
      end
    end
    tests++; if (fs_cnt != 2) begin failed++; $display("FAIL small_fs_count: got %0d want 2", fs_cnt); end
    tests++; if (vb_cnt != 120 || vb_first != 192) begin failed++; $display("FAIL small_vblank: got cnt=%0d first=%0d want 120 192", vb_cnt, vb_first); end
    tests++; if (vs_cnt != 48 || vs_first != 219) begin failed++; $display("FAIL small_vsync: got cnt=%0d first=%0d want 48 219", vs_cnt, vs_first); end
    tests++; if (hs_cnt != 39) begin failed++; $display("FAIL small_hsync_count: got %0d want 39", hs_cnt); end
    $display("[TB] test_small_frame done: vs first=%0d hs cnt=%0d", vs_first, hs_cnt);
  endtask

  task automatic test_midframe_reset();
    apply_reset();
    while (n != 100) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({r_b, g_b, b_b} !== 12'h000) begin failed++; $display("FAIL midrst_rgb_b: got %h want 000", {r_b, g_b, b_b}); end
    tests++; if ({hs_b, vs_b, hs_a, vs_a} !== 4'b0011) begin failed++; $display("FAIL midrst_sync: got %b want 0011", {hs_b, vs_b, hs_a, vs_a}); end
    tests++; if (addr_b !== 8'd0) begin failed++; $display("FAIL midrst_addr_b: got %0d want 0", addr_b); end
    tests++; if (fs_b !== 1'b1 || vb_b !== 1'b0) begin failed++; $display("FAIL midrst_flags_b: got fs=%b vb=%b want 1 0", fs_b, vb_b); end
    @(negedge clk);
    tests++; if (r_b !== 4'h0 || fs_b !== 1'b0) begin failed++; $display("FAIL midrst_n1: got r=%h fs=%b want 0 0", r_b, fs_b); end
    @(negedge clk);
    tests++; if (r_b !== 4'h0) begin failed++; $display("FAIL midrst_n2_stale: got %h want 0", r_b); end
    @(negedge clk);
    tests++; if (r_b !== 4'hF) begin failed++; $display("FAIL midrst_n3_pix00: got %h want f", r_b); end
    $display("[TB] test_midframe_reset done");
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    tp = 1'b1;
    apply_reset();
    for (int t = 0; t <= 60; t++) begin
      @(negedge clk);
      if (n == 9) begin
        tests++; if (r_a !== 4'h0) begin failed++; $display("FAIL pattern_h5: got %h want 0", r_a); end
      end
      if (n == 57) begin
        tests++; if ({r_a, g_a, b_a} !== 12'h333) begin failed++; $display("FAIL pattern_h35: got %h want 333", {r_a, g_a, b_a}); end
      end
    end
    tp = 1'b0;
    $display("[TB] test_pattern done");
  endtask
`endif

  initial begin
    test_reset();
    test_hsync_timing();
    test_pixel_path();
    test_scaling();
    test_small_frame();
    test_midframe_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
